// File: rtl/apb_uart_master_if.sv
// APB bus between the UART master sequencer and the UART register slave.
interface apb_uart_master_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [4:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_uart_master.sv
// APB master that configures a UART slave at start-up, then polls its STATUS
// register and moves bytes between a TX stream, the UART and an RX holding
// register, collecting sticky error flags along the way.
module apb_uart_master #(
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter bit          PRG_BIT8   = 1'b1,
  parameter int          PRG_PARITY = 0
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  apb_uart_master_if.master apb,
  input  logic [7:0]        TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic [7:0]        RX_DATA,
  output logic              RX_VALID,
  input  logic              RX_READY,
  output logic [3:0]        ERR_FLAGS,
  input  logic              ERR_CLR,
  output logic              CFG_DONE
);

  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_RXDATA = 5'h04;
  localparam logic [4:0] ADDR_CTRL1  = 5'h08;
  localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;

  localparam logic [7:0] CTRL1_VAL = BAUD_VALUE[7:0];
  localparam logic [7:0] CTRL2_VAL = {BAUD_VALUE[12:8], (PRG_PARITY == 2),
                                      (PRG_PARITY != 0), PRG_BIT8};

  typedef enum logic [2:0] {
    S_CFG1,
    S_CFG2,
    S_POLL,
    S_TXWR,
    S_RXRD
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_psel;
  logic       r_penable;
  logic       w_penable_nxt;
  logic       w_done;
  logic       w_start;
  logic [4:0] r_paddr;
  logic       r_pwrite;
  logic [7:0] r_pwdata;
  logic       r_tx_ready;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic [3:0] r_err_flags;
  logic [3:0] w_err_cap;
  logic       r_cfg_done;

  function automatic logic [4:0] f_addr(input state_t s);
    case (s)
      S_CFG1:  f_addr = ADDR_CTRL1;
      S_CFG2:  f_addr = ADDR_CTRL2;
      S_POLL:  f_addr = ADDR_STATUS;
      S_TXWR:  f_addr = ADDR_TXDATA;
      default: f_addr = ADDR_RXDATA;
    endcase
  endfunction

  function automatic logic f_write(input state_t s);
    f_write = (s == S_CFG1) || (s == S_CFG2) || (s == S_TXWR);
  endfunction

  // Write data for the configuration writes; TXDATA is filled from TX_DATA
  // during its SETUP cycle, reads carry zero.
  function automatic logic [7:0] f_wdata(input state_t s);
    case (s)
      S_CFG1:  f_wdata = CTRL1_VAL;
      S_CFG2:  f_wdata = CTRL2_VAL;
      default: f_wdata = 8'h00;
    endcase
  endfunction

  // Sequencer state and APB phase registers.
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      r_state   <= S_CFG1;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_psel    <= 1'b1;
      r_penable <= w_penable_nxt;
    end
  end

  // Next transfer selection: a transfer starts right after reset release and
  // immediately after the previous one completes; POLL favours RX over TX.
  always_comb begin
    w_state_nxt   = r_state;
    w_penable_nxt = r_penable;
    w_start       = 1'b0;
    w_done        = r_psel && r_penable && apb.PREADY;
    if (!r_psel) begin
      w_state_nxt   = S_CFG1;
      w_start       = 1'b1;
      w_penable_nxt = 1'b0;
    end else if (w_done) begin
      w_start       = 1'b1;
      w_penable_nxt = 1'b0;
      unique case (r_state)
        S_CFG1: w_state_nxt = S_CFG2;
        S_CFG2: w_state_nxt = S_POLL;
        S_POLL: begin
          if (apb.PRDATA[1] && !r_rx_valid)
            w_state_nxt = S_RXRD;
          else if (apb.PRDATA[0] && TX_VALID)
            w_state_nxt = S_TXWR;
          else
            w_state_nxt = S_POLL;
        end
        default: w_state_nxt = S_POLL;
      endcase
    end else begin
      w_penable_nxt = 1'b1;
    end
  end

  // Error bits captured at transfer completion: STATUS error bits on a poll,
  // slave error on any transfer.
  always_comb begin
    w_err_cap = 4'h0;
    if (w_done && (r_state == S_POLL))
      w_err_cap[2:0] = apb.PRDATA[4:2];
    if (w_done && apb.PSLVERR)
      w_err_cap[3] = 1'b1;
  end

  // Address/control/data held for each transfer; TX byte latched at the end
  // of the TXWR SETUP cycle, which is when TX_READY is high.
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      r_paddr    <= 5'h00;
      r_pwrite   <= 1'b0;
      r_pwdata   <= 8'h00;
      r_tx_ready <= 1'b0;
    end else begin
      r_tx_ready <= w_start && (w_state_nxt == S_TXWR);
      if (w_start) begin
        r_paddr  <= f_addr(w_state_nxt);
        r_pwrite <= f_write(w_state_nxt);
        r_pwdata <= f_wdata(w_state_nxt);
      end else if (r_tx_ready) begin
        r_pwdata <= TX_DATA;
      end
    end
  end

  // RX holding register, sticky error flags and configuration-done flag.
  always_ff @(posedge PCLK) begin
    if (!PRESETN) begin
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_err_flags <= 4'h0;
      r_cfg_done  <= 1'b0;
    end else begin
      if (w_done && (r_state == S_RXRD)) begin
        r_rx_data  <= apb.PRDATA;
        r_rx_valid <= 1'b1;
      end else if (RX_READY) begin
        r_rx_valid <= 1'b0;
      end
      if (w_done && (r_state == S_CFG2))
        r_cfg_done <= 1'b1;
      r_err_flags <= (ERR_CLR ? 4'h0 : r_err_flags) | w_err_cap;
    end
  end

  assign apb.PSEL    = r_psel;
  assign apb.PENABLE = r_penable;
  assign apb.PWRITE  = r_pwrite;
  assign apb.PADDR   = r_paddr;
  assign apb.PWDATA  = r_tx_ready ? TX_DATA : r_pwdata;
  assign TX_READY    = r_tx_ready;
  assign RX_DATA     = r_rx_data;
  assign RX_VALID    = r_rx_valid;
  assign ERR_FLAGS   = r_err_flags;
  assign CFG_DONE    = r_cfg_done;

endmodule

// File: tb/tb_apb_uart_master.sv
// Bench for apb_uart_master: a UART register slave with a loopback byte queue,
// a transaction-level reference model checked every cycle, directed scenarios
// with literal expectations, then a randomized run.
module tb_apb_uart_master;
  localparam logic [12:0] BAUD = 13'h123;
  localparam int          PAR  = 2;
  localparam logic [7:0]  CTRL2 = {BAUD[12:8], (PAR == 2), (PAR != 0), 1'b1};
  localparam int K_CFG1 = 0, K_CFG2 = 1, K_POLL = 2, K_TX = 3, K_RX = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [3:0] err_flags;
  logic       err_clr = 1'b0;
  logic       cfg_done;

  apb_uart_master_if bus();

  apb_uart_master #(.BAUD_VALUE(BAUD), .PRG_BIT8(1'b1), .PRG_PARITY(PAR)) dut (
    .PCLK(clk), .PRESETN(rst_n), .apb(bus),
    .TX_DATA(tx_data), .TX_VALID(tx_valid), .TX_READY(tx_ready),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_READY(rx_ready),
    .ERR_FLAGS(err_flags), .ERR_CLR(err_clr), .CFG_DONE(cfg_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: the transfer in flight and the visible output registers
  bit         m_active, m_acc, m_txrdy, m_rxv, m_done, m_hs;
  int         m_kind;
  logic [4:0] m_addr;
  bit         m_wr;
  logic [7:0] m_wdata, m_rxd;
  logic [3:0] m_err;

  // scenario controls and slave state
  bit         g_rst = 1'b0, g_rand = 1'b0, g_rst_arm = 1'b0, g_slverr_once = 1'b0;
  bit         g_txrdy = 1'b1, g_rxready = 1'b0, g_errclr = 1'b0, g_status_once = 1'b0;
  int         g_stall = 0, g_status_force = -1, g_status_next = -1;
  logic [7:0] g_rxfill = 8'h3C;
  bit         tx_pend = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic [7:0] uq[$];
  int         addr_log[$];
  int         n_txwr = 0, n_txpulse = 0;
  logic [7:0] last_wr = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_start(input int k);
    m_active = 1'b1;
    m_acc    = 1'b0;
    m_kind   = k;
    m_txrdy  = (k == K_TX);
    case (k)
      K_CFG1:  begin m_addr = 5'h08; m_wr = 1'b1; m_wdata = BAUD[7:0]; end
      K_CFG2:  begin m_addr = 5'h0C; m_wr = 1'b1; m_wdata = CTRL2;     end
      K_POLL:  begin m_addr = 5'h10; m_wr = 1'b0; m_wdata = 8'h00;     end
      K_TX:    begin m_addr = 5'h00; m_wr = 1'b1; m_wdata = 8'h00;     end
      default: begin m_addr = 5'h04; m_wr = 1'b0; m_wdata = 8'h00;     end
    endcase
  endtask

  // Advance the model across the rising edge that just happened, using the
  // inputs that were presented at that edge.
  task automatic model_step();
    bit         done, old_rxv;
    logic [3:0] cap;
    int         nk;
    m_hs = m_txrdy && tx_valid;
    if (!rst_n) begin
      m_active = 1'b0; m_acc = 1'b0; m_kind = K_CFG1; m_addr = 5'h00; m_wr = 1'b0;
      m_wdata = 8'h00; m_txrdy = 1'b0; m_rxd = 8'h00; m_rxv = 1'b0; m_err = 4'h0;
      m_done = 1'b0;
    end else begin
      done    = m_active && m_acc && bus.PREADY;
      old_rxv = m_rxv;
      cap     = 4'h0;
      if (done && m_kind == K_POLL) cap[2:0] = bus.PRDATA[4:2];
      if (done && bus.PSLVERR) cap[3] = 1'b1;
      m_err = (err_clr ? 4'h0 : m_err) | cap;
      if (done && m_kind == K_RX) begin
        m_rxd = bus.PRDATA;
        m_rxv = 1'b1;
      end else if (rx_ready) begin
        m_rxv = 1'b0;
      end
      if (done && m_kind == K_CFG2) m_done = 1'b1;
      if (m_txrdy) m_wdata = tx_data;
      if (!m_active) begin
        m_start(K_CFG1);
      end else if (done) begin
        case (m_kind)
          K_CFG1: nk = K_CFG2;
          K_CFG2: nk = K_POLL;
          K_POLL: begin
            if (bus.PRDATA[1] && !old_rxv)      nk = K_RX;
            else if (bus.PRDATA[0] && tx_valid) nk = K_TX;
            else                                nk = K_POLL;
          end
          default: nk = K_POLL;
        endcase
        m_start(nk);
      end else begin
        m_acc   = 1'b1;
        m_txrdy = 1'b0;
      end
    end
  endtask

  task automatic compare();
    chk("PSEL", bus.PSEL, m_active);
    chk("PENABLE", bus.PENABLE, m_acc);
    chk("PADDR", bus.PADDR, m_addr);
    chk("PWRITE", bus.PWRITE, m_wr);
    chk("PWDATA", bus.PWDATA, m_txrdy ? tx_data : m_wdata);
    chk("TX_READY", tx_ready, m_txrdy);
    chk("RX_DATA", rx_data, m_rxd);
    chk("RX_VALID", rx_valid, m_rxv);
    chk("ERR_FLAGS", err_flags, m_err);
    chk("CFG_DONE", cfg_done, m_done);
    if (tx_ready) n_txpulse++;
    if (bus.PSEL && !bus.PENABLE) addr_log.push_back(int'(bus.PADDR));
  endtask

  // Present the inputs for the current cycle: reset, slave response, streams.
  task automatic drive();
    bit         rdy, serr;
    logic [7:0] st, rd;
    rst_n = g_rst;
    if (g_rst_arm && bus.PSEL && bus.PENABLE && bus.PWRITE && bus.PADDR == 5'h00) begin
      rst_n     = 1'b0;
      g_rst_arm = 1'b0;
    end
    if (g_rand && $urandom_range(0, 399) == 0) rst_n = 1'b0;

    rdy  = 1'b1;
    serr = 1'b0;
    if (bus.PSEL && bus.PENABLE) begin
      if (g_stall > 0 && bus.PADDR == 5'h10) begin
        rdy = 1'b0;
        g_stall--;
      end else if (g_rand) begin
        rdy = ($urandom_range(0, 3) != 0);
      end
      if (rdy && g_slverr_once) begin
        serr          = 1'b1;
        g_slverr_once = 1'b0;
      end else if (rdy && g_rand) begin
        serr = ($urandom_range(0, 24) == 0);
      end
    end else if (g_rand) begin
      rdy  = 1'($urandom_range(0, 1));
      serr = 1'($urandom_range(0, 1));
    end

    if (g_status_force >= 0) begin
      st = g_status_force[7:0];
    end else begin
      st    = 8'h00;
      st[0] = g_rand ? ($urandom_range(0, 4) != 0) : g_txrdy;
      st[1] = (uq.size() != 0);
      if (g_rand && $urandom_range(0, 29) == 0) st[4:2] = 3'($urandom_range(1, 7));
      if (g_rand) st[7:5] = 3'($urandom);
    end
    case (bus.PADDR)
      5'h10:   rd = st;
      5'h04:   rd = (uq.size() != 0) ? uq[0] : g_rxfill;
      default: rd = g_rand ? 8'($urandom) : 8'h00;
    endcase

    if (rst_n && bus.PSEL && bus.PENABLE && rdy) begin
      if (bus.PWRITE && bus.PADDR == 5'h00) begin
        uq.push_back(bus.PWDATA);
        n_txwr++;
        last_wr = bus.PWDATA;
      end
      if (!bus.PWRITE && bus.PADDR == 5'h04 && uq.size() != 0) void'(uq.pop_front());
      if (bus.PADDR == 5'h10 && g_status_once) begin
        g_status_force = g_status_next;
        g_status_once  = 1'b0;
      end
    end
    bus.PREADY  = rdy;
    bus.PSLVERR = serr;
    bus.PRDATA  = rd;

    if (m_hs) tx_pend = 1'b0;
    if (g_rand && !tx_pend && $urandom_range(0, 2) == 0) begin
      tx_pend = 1'b1;
      tx_byte = 8'($urandom);
    end
    tx_valid = tx_pend;
    tx_data  = tx_pend ? tx_byte : (g_rand ? 8'($urandom) : 8'h00);
    rx_ready = g_rand ? ($urandom_range(0, 1) == 1) : g_rxready;
    err_clr  = g_rand ? ($urandom_range(0, 29) == 0) : g_errclr;
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
    compare();
    drive();
  endtask

  // Advance until a SETUP cycle (optionally for one address) is visible.
  task automatic wait_setup(input int addr, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      cyc();
      if (bus.PSEL && !bus.PENABLE && (addr < 0 || int'(bus.PADDR) == addr)) hit = 1'b1;
    end
    chk(tag, hit, 1);
  endtask

  initial begin
    int acc, irx, itx, nrx, ntx;
    bit hit;
    bus.PREADY  = 1'b1;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = 8'h00;

    // reset state
    g_rst = 1'b0;
    repeat (3) cyc();
    chk("rst_PSEL", bus.PSEL, 0);
    chk("rst_PENABLE", bus.PENABLE, 0);
    chk("rst_PADDR", bus.PADDR, 0);
    chk("rst_CFG_DONE", cfg_done, 0);
    chk("rst_ERR", err_flags, 0);
    chk("rst_RX_VALID", rx_valid, 0);
    chk("rst_TX_READY", tx_ready, 0);

    // start-up writes: CTRL1=0x23, CTRL2=0x0F, CFG_DONE in cycle 5
    g_rst = 1'b1;
    cyc();
    cyc();
    chk("c1_PSEL", bus.PSEL, 1);
    chk("c1_PENABLE", bus.PENABLE, 0);
    chk("c1_PADDR", bus.PADDR, 5'h08);
    chk("c1_PWRITE", bus.PWRITE, 1);
    chk("c1_PWDATA", bus.PWDATA, 8'h23);
    cyc();
    chk("c2_PENABLE", bus.PENABLE, 1);
    chk("c2_PWDATA", bus.PWDATA, 8'h23);
    cyc();
    chk("c3_PADDR", bus.PADDR, 5'h0C);
    chk("c3_PWDATA", bus.PWDATA, 8'h0F);
    chk("c3_PENABLE", bus.PENABLE, 0);
    cyc();
    chk("c4_CFG_DONE", cfg_done, 0);
    cyc();
    chk("c5_CFG_DONE", cfg_done, 1);
    chk("c5_PADDR", bus.PADDR, 5'h10);

    // loopback of 0xA5
    uq.delete();
    n_txpulse = 0;
    n_txwr    = 0;
    tx_pend   = 1'b1;
    tx_byte   = 8'hA5;
    hit       = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      cyc();
      if (rx_valid) hit = 1'b1;
    end
    chk("lb_RX_VALID", hit, 1);
    chk("lb_RX_DATA", rx_data, 8'hA5);
    chk("lb_TX_READY_pulses", n_txpulse, 1);
    chk("lb_TXWR_count", n_txwr, 1);
    chk("lb_TXWR_data", last_wr, 8'hA5);

    // three wait states in a poll
    wait_setup(5'h10, "ws_setup");
    g_stall = 3;
    acc     = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (!bus.PENABLE) break;
      acc++;
      chk("ws_PADDR", bus.PADDR, 5'h10);
      chk("ws_PSEL", bus.PSEL, 1);
    end
    chk("ws_access_len", acc, 4);

    // RX before TX, then backpressure holds off further RX reads
    g_rxready = 1'b1;
    cyc();
    g_rxready      = 1'b0;
    uq.delete();
    addr_log.delete();
    g_status_force = 8'h03;
    g_rxfill       = 8'h3C;
    tx_pend        = 1'b1;
    tx_byte        = 8'h5A;
    repeat (40) cyc();
    irx = -1; itx = -1; nrx = 0; ntx = 0;
    foreach (addr_log[j]) begin
      if (addr_log[j] == 5'h04) begin nrx++; if (irx < 0) irx = j; end
      if (addr_log[j] == 5'h00) begin ntx++; if (itx < 0) itx = j; end
    end
    chk("pri_rx_count", nrx, 1);
    chk("pri_tx_count", ntx, 1);
    chk("pri_rx_first", (irx >= 0 && irx < itx), 1);
    chk("pri_RX_DATA", rx_data, 8'h3C);
    chk("pri_RX_VALID", rx_valid, 1);

    // STATUS 0x14 then a slave error: parity+framing+apb_err
    g_status_force = 8'h00;
    g_errclr = 1'b1;
    cyc();
    g_errclr = 1'b0;
    wait_setup(5'h10, "err_setup");
    g_status_force = 8'h14;
    g_status_next  = 8'h00;
    g_status_once  = 1'b1;
    wait_setup(-1, "err_after_status");
    g_slverr_once = 1'b1;
    wait_setup(-1, "err_after_slverr");
    chk("err_flags_set", err_flags, 4'hD);
    g_errclr = 1'b1;
    cyc();
    g_errclr = 1'b0;
    cyc();
    chk("err_flags_clr", err_flags, 4'h0);

    // reset in the ACCESS phase of a TX write
    g_status_force = 8'h01;
    tx_pend        = 1'b1;
    tx_byte        = 8'h77;
    g_rst_arm      = 1'b1;
    hit            = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      cyc();
      if (!rst_n) hit = 1'b1;
    end
    chk("rr_reset_hit", hit, 1);
    cyc();
    chk("rr_PSEL", bus.PSEL, 0);
    chk("rr_CFG_DONE", cfg_done, 0);
    cyc();
    chk("rr_PSEL_restart", bus.PSEL, 1);
    chk("rr_PADDR_restart", bus.PADDR, 5'h08);
    chk("rr_PWDATA_restart", bus.PWDATA, 8'h23);

    // randomized traffic
    g_status_force = -1;
    g_status_once  = 1'b0;
    g_rst_arm      = 1'b0;
    uq.delete();
    addr_log.delete();
    g_rand = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if (addr_log.size() > 64) addr_log.delete();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
